// File: rtl/memory_stage.sv
// Y86-64 memory stage: owns the byte-addressed data memory, performs the load or
// store selected by icode, and hands the registered results plus status to write_back.
module memory_stage #(
  parameter int MEM_BYTES   = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic        imem_error,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic        cnd_o,
  output logic [63:0] valA_o,
  output logic [63:0] valE_o,
  output logic [63:0] valP_o,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [3:0]      icode_q, ra_q, rb_q;
  logic            cnd_q;
  logic [63:0]     vala_q, vale_q, valp_q, valm_q;
  logic            dmem_err_q;
  stat_e           stat_q;
  logic            is_wr_q, is_rd_q;
  logic [AW-1:0]   addr_idx_q;

  // Decode of the instruction currently offered by execute.
  logic            is_wr_in, is_rd_in, ins_in, mem_op_in, range_err_in;
  logic [63:0]     addr_in;
  stat_e           stat_in;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_wr_in     = (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    is_rd_in     = (icode == I_MRMOVQ) || (icode == I_RET)  || (icode == I_POPQ);
    addr_in      = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
    ins_in       = imem_error || (icode > 4'd11);
    mem_op_in    = (is_wr_in || is_rd_in) && !ins_in;
    range_err_in = mem_op_in && (addr_in > 64'(MEM_BYTES - 8));
    if (ins_in)                stat_in = STAT_INS;
    else if (range_err_in)     stat_in = STAT_ADR;
    else if (icode == I_HALT)  stat_in = STAT_HLT;
    else                       stat_in = STAT_AOK;
  end

  logic accept, access_now, mem_we, mem_re;
  logic [63:0] rdata, wdata;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign accept     = in_ready && in_valid;
  assign access_now = (state_q == S_ACCESS) && (cnt_q == '0);
  assign mem_we     = access_now && is_wr_q && !dmem_err_q;
  assign mem_re     = access_now && is_rd_q && !dmem_err_q;
  assign wdata      = (icode_q == I_CALL) ? valp_q : vala_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = mem_op_in ? S_ACCESS : S_DONE;
      S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = (stat_q != STAT_AOK) ? S_HALTED : S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      icode_q    <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      cnd_q      <= 1'b0;
      vala_q     <= '0;
      vale_q     <= '0;
      valp_q     <= '0;
      valm_q     <= '0;
      dmem_err_q <= 1'b0;
      stat_q     <= STAT_AOK;
      is_wr_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      addr_idx_q <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= 4'(MEM_LATENCY - 1);
        icode_q    <= icode;
        ra_q       <= rA;
        rb_q       <= rB;
        cnd_q      <= cnd;
        vala_q     <= valA;
        vale_q     <= valE;
        valp_q     <= valP;
        valm_q     <= '0;
        dmem_err_q <= range_err_in;
        stat_q     <= stat_in;
        is_wr_q    <= is_wr_in;
        is_rd_q    <= is_rd_in;
        addr_idx_q <= addr_in[AW-1:0];
      end else if ((state_q == S_ACCESS) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (mem_re) valm_q <= rdata;
    end
  end

  logic [7:0] mem [MEM_BYTES];

  // Little-endian, unaligned 8-byte window starting at the captured address.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[addr_idx_q + AW'(i)];
  end

  // NOTE: the data memory is deliberately not reset; contents survive rst_n and it can map to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) mem[addr_idx_q + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  assign icode_o    = icode_q;
  assign rA_o       = ra_q;
  assign rB_o       = rb_q;
  assign cnd_o      = cnd_q;
  assign valA_o     = vala_q;
  assign valE_o     = vale_q;
  assign valP_o     = valp_q;
  assign valM       = valm_q;
  assign dmem_error = dmem_err_q;
  assign stat       = stat_q;

endmodule
